// File: rtl/fft_spectrum_buf_if.sv
// Spectrum buffer bus: FFT bin stream in, display read port and frame status out.
// The master drives the stream and read requests; the slave is the buffer itself.
interface fft_spectrum_buf_if #(
    parameter int ADDR_W = 7,
    parameter int OUT_W  = 10
);
    logic              data_sop;
    logic              data_eop;
    logic              data_valid;
    logic [31:0]       data_modulus;
    logic              disp_lock;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              frame_done;
    logic              frame_err;
    logic [ADDR_W-1:0] peak_bin;
    logic [OUT_W-1:0]  peak_val;
    logic              bank_ready;

    modport master (
        output data_sop, data_eop, data_valid, data_modulus, disp_lock, rd_en, rd_addr,
        input  rd_data, rd_valid, frame_done, frame_err, peak_bin, peak_val, bank_ready
    );

    modport slave (
        input  data_sop, data_eop, data_valid, data_modulus, disp_lock, rd_en, rd_addr,
        output rd_data, rd_valid, frame_done, frame_err, peak_bin, peak_val, bank_ready
    );
endinterface

// File: rtl/fft_spectrum_buf.sv
// Ping-pong spectrum buffer: captures one FFT frame of bin magnitudes, scales and
// saturates them to display height, keeps the lower half of the spectrum and its
// peak, and only exposes a bank to the reader once the whole frame is in.
module fft_spectrum_buf #(
    parameter int FFT_N  = 256,
    parameter int ADDR_W = 7,
    parameter int OUT_W  = 10,
    parameter int SHIFT  = 8
) (
    input logic              clk_50m,
    input logic              rst,
    fft_spectrum_buf_if.slave bus
);
    localparam int CNT_W = $clog2(FFT_N);
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_N - 1);
    localparam logic [CNT_W-1:0] HALF_BIN = CNT_W'(FFT_N / 2);

    typedef enum logic [1:0] {IDLE, CAPTURE, SWAP} state_t;

    state_t              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]    bin_cnt_q, bin_cnt_d;
    logic [ADDR_W-1:0]   cap_bin_q, cap_bin_d;
    logic [OUT_W-1:0]    cap_val_q, cap_val_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [OUT_W-1:0]    peak_val_q, peak_val_d;
    logic                bank_ready_q, bank_ready_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;

    logic                wr_en;
    logic [ADDR_W:0]     wr_addr;
    logic [31:0]         shifted;
    logic [OUT_W-1:0]    stored;
    logic [OUT_W-1:0]    rd_data_q;
    logic                rd_valid_q;

    // Both banks live in one array; the top address bit selects the bank.
    logic [OUT_W-1:0]    ram [2**(ADDR_W+1)];

    assign shifted = bus.data_modulus >> SHIFT;
    assign stored  = (|shifted[31:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

    // Frame FSM and capture datapath: next state, RAM write and peak tracking.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        bin_cnt_d    = bin_cnt_q;
        cap_bin_d    = cap_bin_q;
        cap_val_d    = cap_val_q;
        peak_bin_d   = peak_bin_q;
        peak_val_d   = peak_val_q;
        bank_ready_d = bank_ready_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = {wr_bank_q, bin_cnt_q[ADDR_W-1:0]};

        unique case (state_q)
            IDLE: begin
                if (bus.data_valid && bus.data_sop) begin
                    if (bus.data_eop) begin
                        frame_err_d = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        wr_addr   = {wr_bank_q, {ADDR_W{1'b0}}};
                        bin_cnt_d = CNT_W'(1);
                        cap_bin_d = '0;
                        cap_val_d = stored;
                        state_d   = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (bus.data_valid) begin
                    if (bus.data_sop) begin
                        // A fresh sop aborts the frame in flight; eop on the same beat is malformed.
                        frame_err_d = 1'b1;
                        if (bus.data_eop) begin
                            state_d = IDLE;
                        end else begin
                            wr_en     = 1'b1;
                            wr_addr   = {wr_bank_q, {ADDR_W{1'b0}}};
                            bin_cnt_d = CNT_W'(1);
                            cap_bin_d = '0;
                            cap_val_d = stored;
                        end
                    end else begin
                        // Only the lower half of the spectrum is kept; strict > keeps the lowest index on ties.
                        if (bin_cnt_q < HALF_BIN) begin
                            wr_en = 1'b1;
                            if (stored > cap_val_q) begin
                                cap_bin_d = bin_cnt_q[ADDR_W-1:0];
                                cap_val_d = stored;
                            end
                        end
                        if (bin_cnt_q == LAST_BIN) begin
                            if (bus.data_eop) begin
                                state_d = SWAP;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = IDLE;
                            end
                        end else if (bus.data_eop) begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            bin_cnt_d = bin_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            SWAP: begin
                // Input beats are dropped here; the reader holds the bank while disp_lock is high.
                if (!bus.disp_lock) begin
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
                    peak_bin_d   = cap_bin_q;
                    peak_val_d   = cap_val_q;
                    bank_ready_d = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk_50m) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bin_cnt_q    <= '0;
            cap_bin_q    <= '0;
            cap_val_q    <= '0;
            peak_bin_q   <= '0;
            peak_val_q   <= '0;
            bank_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bin_cnt_q    <= bin_cnt_d;
            cap_bin_q    <= cap_bin_d;
            cap_val_q    <= cap_val_d;
            peak_bin_q   <= peak_bin_d;
            peak_val_q   <= peak_val_d;
            bank_ready_q <= bank_ready_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Capture write port into the bank being filled.
    always_ff @(posedge clk_50m) begin
        // NOTE: the RAM is deliberately not reset; bank_ready gates what the reader can see.
        if (wr_en) begin
            ram[wr_addr] <= stored;
        end
    end

    // Registered read port on the display bank; rd_bank is the pre-swap value during a swap edge.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= bank_ready_q ? ram[{rd_bank_q, bus.rd_addr}] : '0;
            end
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_val   = peak_val_q;
    assign bus.bank_ready = bank_ready_q;
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Directed bench for fft_spectrum_buf: frames are streamed beat by beat, a
// reference copy of the displayed bank predicts each read, and expected read
// data waits in a queue until rd_valid comes back.
module tb_fft_spectrum_buf;
    logic clk_50m;
    logic rst;

    fft_spectrum_buf_if #(.ADDR_W(7), .OUT_W(10)) ifc ();

    fft_spectrum_buf dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (ifc)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;

    logic [31:0] fd [256];
    logic [9:0]  pend [128];
    logic [9:0]  disp [128];
    logic [6:0]  pend_pk_bin;
    logic [9:0]  pend_pk_val;
    bit          model_ready = 1'b0;
    logic [9:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] scale(input logic [31:0] d);
        logic [31:0] s;
        s = d >> 8;
        return (s > 32'd1023) ? 10'd1023 : s[9:0];
    endfunction

    // Reference result of the frame currently held in fd, used if it completes.
    task automatic set_pending();
        for (int i = 0; i < 128; i++) pend[i] = scale(fd[i]);
        pend_pk_bin = 7'd0;
        pend_pk_val = pend[0];
        for (int i = 1; i < 128; i++) begin
            if (pend[i] > pend_pk_val) begin
                pend_pk_val = pend[i];
                pend_pk_bin = 7'(i);
            end
        end
    endtask

    // One clock: outputs sampled 1 ns after the edge, inputs changed there too.
    task automatic step();
        @(posedge clk_50m);
        #1;
        if (ifc.frame_done) begin
            done_cnt++;
            check("done_peak_bin", 32'(ifc.peak_bin), 32'(pend_pk_bin));
            check("done_peak_val", 32'(ifc.peak_val), 32'(pend_pk_val));
            check("done_bank_ready", 32'(ifc.bank_ready), 32'd1);
            for (int i = 0; i < 128; i++) disp[i] = pend[i];
            model_ready = 1'b1;
        end
        if (ifc.frame_err) err_cnt++;
        if (ifc.rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_data", 32'(ifc.rd_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic [31:0] d, input bit sop, input bit eop);
        ifc.data_valid   = 1'b1;
        ifc.data_modulus = d;
        ifc.data_sop     = sop;
        ifc.data_eop     = eop;
        step();
        ifc.data_valid = 1'b0;
        ifc.data_sop   = 1'b0;
        ifc.data_eop   = 1'b0;
    endtask

    // Beats first..last of fd; sop on beat 0, optional eop on the last, one idle gap at beat 64.
    task automatic send_range(input int first, input int last, input bit with_eop, input bit lock_last);
        for (int i = first; i <= last; i++) begin
            if (i == 64) idle(1);
            if (lock_last && i == last) ifc.disp_lock = 1'b1;
            beat(fd[i], i == 0, with_eop && i == last);
        end
    endtask

    task automatic read_bin(input int a);
        ifc.rd_en   = 1'b1;
        ifc.rd_addr = 7'(a);
        exp_q.push_back(model_ready ? disp[a] : 10'd0);
        step();
        ifc.rd_en = 1'b0;
    endtask

    int d0, e0;

    initial begin
        rst              = 1'b1;
        ifc.data_sop     = 1'b0;
        ifc.data_eop     = 1'b0;
        ifc.data_valid   = 1'b0;
        ifc.data_modulus = '0;
        ifc.disp_lock    = 1'b0;
        ifc.rd_en        = 1'b0;
        ifc.rd_addr      = '0;
        idle(2);
        rst = 1'b0;
        step();

        // Reset state
        check("rst_rd_data", 32'(ifc.rd_data), 32'd0);
        check("rst_rd_valid", 32'(ifc.rd_valid), 32'd0);
        check("rst_frame_done", 32'(ifc.frame_done), 32'd0);
        check("rst_frame_err", 32'(ifc.frame_err), 32'd0);
        check("rst_peak_bin", 32'(ifc.peak_bin), 32'd0);
        check("rst_peak_val", 32'(ifc.peak_val), 32'd0);
        check("rst_bank_ready", 32'(ifc.bank_ready), 32'd0);

        // Stray beats without sop are ignored; sop with eop on one beat is malformed
        d0 = done_cnt; e0 = err_cnt;
        beat(32'd123, 1'b0, 1'b0);
        beat(32'd5, 1'b0, 1'b1);
        check("idle_stray_err", 32'(err_cnt - e0), 32'd0);
        beat(32'd77, 1'b1, 1'b1);
        idle(2);
        check("sop_eop_err", 32'(err_cnt - e0), 32'd1);

        // Early eop at beat 100: error, nothing displayable
        for (int k = 0; k < 256; k++) fd[k] = 32'(k) << 8;
        d0 = done_cnt; e0 = err_cnt;
        send_range(0, 100, 1'b1, 1'b0);
        idle(3);
        check("early_eop_err", 32'(err_cnt - e0), 32'd1);
        check("early_eop_done", 32'(done_cnt - d0), 32'd0);
        check("early_eop_ready", 32'(ifc.bank_ready), 32'd0);
        read_bin(5);

        // Good ramp frame: bin k stores k, peak is the top stored bin
        set_pending();
        d0 = done_cnt; e0 = err_cnt;
        send_range(0, 255, 1'b1, 1'b0);
        idle(3);
        check("ramp_done", 32'(done_cnt - d0), 32'd1);
        check("ramp_err", 32'(err_cnt - e0), 32'd0);
        check("ramp_rd_hold", 32'(ifc.rd_data), 32'd0);
        read_bin(5);
        read_bin(0);
        read_bin(127);
        check("ramp_peak_bin", 32'(ifc.peak_bin), 32'd127);
        check("ramp_peak_val", 32'(ifc.peak_val), 32'd127);

        // Overrun: 256 beats with no eop is discarded, display untouched
        d0 = done_cnt; e0 = err_cnt;
        send_range(0, 255, 1'b0, 1'b0);
        idle(3);
        check("overrun_err", 32'(err_cnt - e0), 32'd1);
        check("overrun_done", 32'(done_cnt - d0), 32'd0);
        read_bin(100);

        // Saturation, exact full scale, tie on max, upper-half bins never stored
        for (int k = 0; k < 256; k++) fd[k] = 32'd0;
        fd[3]   = 32'hFFFF_FFFF;
        fd[10]  = (32'd1023 << 8) | 32'hFF;
        fd[11]  = 32'd1024 << 8;
        fd[100] = 32'hFFFF_FFFF;
        fd[200] = 32'hFFFF_FFFF;
        set_pending();
        d0 = done_cnt;
        send_range(0, 255, 1'b1, 1'b0);
        idle(3);
        check("sat_done", 32'(done_cnt - d0), 32'd1);
        read_bin(3);
        read_bin(9);
        read_bin(10);
        read_bin(11);
        read_bin(72);
        check("sat_peak_bin", 32'(ifc.peak_bin), 32'd3);
        check("sat_peak_val", 32'(ifc.peak_val), 32'd1023);

        // sop at beat 50 restarts: one error, then only the second frame lands
        for (int k = 0; k < 256; k++) fd[k] = 32'(k) << 9;
        d0 = done_cnt; e0 = err_cnt;
        send_range(0, 49, 1'b0, 1'b0);
        for (int k = 0; k < 256; k++) fd[k] = 32'(255 - k) << 8;
        set_pending();
        send_range(0, 255, 1'b1, 1'b0);
        idle(3);
        check("restart_err", 32'(err_cnt - e0), 32'd1);
        check("restart_done", 32'(done_cnt - d0), 32'd1);
        read_bin(0);
        read_bin(50);
        read_bin(127);

        // disp_lock held across eop: swap deferred, next frame dropped silently
        for (int k = 0; k < 256; k++) fd[k] = (32'(k) * 32'd3) << 8;
        set_pending();
        d0 = done_cnt; e0 = err_cnt;
        send_range(0, 255, 1'b1, 1'b1);
        idle(2);
        read_bin(7);
        for (int k = 0; k < 256; k++) fd[k] = 32'(k + 9) << 10;
        send_range(0, 29, 1'b0, 1'b0);
        idle(6);
        check("lock_no_done", 32'(done_cnt - d0), 32'd0);
        check("lock_no_err", 32'(err_cnt - e0), 32'd0);
        ifc.disp_lock = 1'b0;
        step();
        check("lock_release_done", 32'(done_cnt - d0), 32'd1);
        send_range(30, 255, 1'b1, 1'b0);
        idle(3);
        check("dropped_no_err", 32'(err_cnt - e0), 32'd0);
        check("dropped_no_done", 32'(done_cnt - d0), 32'd1);
        read_bin(7);
        read_bin(127);

        // Reset mid-frame: everything back to zero until the next good frame
        for (int k = 0; k < 256; k++) fd[k] = (32'(k) * 32'd2) << 8;
        set_pending();
        send_range(0, 255, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < 256; k++) fd[k] = 32'd7 << 8;
        send_range(0, 119, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_ready = 1'b0;
        check("midrst_ready", 32'(ifc.bank_ready), 32'd0);
        check("midrst_rd_data", 32'(ifc.rd_data), 32'd0);
        check("midrst_peak_bin", 32'(ifc.peak_bin), 32'd0);
        check("midrst_peak_val", 32'(ifc.peak_val), 32'd0);
        check("midrst_frame_done", 32'(ifc.frame_done), 32'd0);
        read_bin(5);
        for (int k = 0; k < 256; k++) fd[k] = 32'(k) << 8;
        set_pending();
        d0 = done_cnt;
        send_range(0, 255, 1'b1, 1'b0);
        idle(3);
        check("restore_done", 32'(done_cnt - d0), 32'd1);
        check("restore_ready", 32'(ifc.bank_ready), 32'd1);
        read_bin(5);
        read_bin(126);
        idle(2);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
